// File: rtl/alu_pkg.sv
// alu_pkg: shared op codes, FSM encoding and result width for the ALU issue controller.
package alu_pkg;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;
    localparam int RES_W = 16;
    typedef enum logic [1:0] {IDLE, DRIVE, RESULT} state_t;
endpackage

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: sequential initiator for the combinational 8-bit ALU.
// Ports: cmd_valid/cmd_ready/cmd_op/cmd_a/cmd_b command handshake in;
//        alu_s/alu_a/alu_b registered drive to the ALU, alu_y/alu_z/alu_o/alu_carry back;
//        res_valid/res_ready/res_data/res_op/res_carry/res_ovf result handshake out;
//        busy high while an operation is in flight.
// Optional: ALU_ISSUE_ZERO_FLAG_EN adds res_zero (captured res_data == 0).
module alu_issue_ctrl import alu_pkg::*; #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    output logic [1:0]       alu_s,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    input  logic [7:0]       alu_y,
    input  logic [15:0]      alu_z,
    input  logic             alu_o,
    input  logic             alu_carry,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [RES_W-1:0] res_data,
    output logic [1:0]       res_op,
    output logic             res_carry,
    output logic             res_ovf,
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    output logic             res_zero,
`endif
    output logic             busy
);
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("alu_issue_ctrl: SETTLE_CYCLES must be in 1..15");
    end
    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);
    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [1:0]       s_q, s_d, op_q, op_d;
    logic [7:0]       a_q, a_d, b_q, b_d;
    logic [RES_W-1:0] data_q, data_d, cap_data;
    logic             carry_q, carry_d, ovf_q, ovf_d;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    logic             zero_q, zero_d;
`endif
    assign cap_data = (s_q == OP_MUL) ? alu_z : {{(RES_W-8){1'b0}}, alu_y};
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        a_d     = a_q;
        b_d     = b_q;
        data_d  = data_q;
        op_d    = op_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
        zero_d  = zero_q;
`endif
        case (state_q)
            IDLE: if (cmd_valid) begin
                state_d = DRIVE;
                cnt_d   = CNT_INIT;
                s_d     = cmd_op;
                a_d     = cmd_a;
                b_d     = cmd_b;
            end
            DRIVE: if (cnt_q == 4'd0) begin
                state_d = RESULT;
                data_d  = cap_data;
                op_d    = s_q;
                // adder flags are always live on the ALU, so mask them for non-add ops
                carry_d = (s_q == OP_ADD) && alu_carry;
                ovf_d   = (s_q == OP_ADD) && alu_o;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
                zero_d  = (cap_data == '0);
`endif
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            RESULT: if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            s_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            op_q    <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
            zero_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            op_q    <= op_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
            zero_q  <= zero_d;
`endif
        end
    end
    assign cmd_ready = (state_q == IDLE);
    assign res_valid = (state_q == RESULT);
    assign busy      = (state_q != IDLE);
    assign alu_s     = s_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign res_data  = data_q;
    assign res_op    = op_q;
    assign res_carry = carry_q;
    assign res_ovf   = ovf_q;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    assign res_zero  = zero_q;
`endif
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: two controllers (settle 1 and 4) each driving a behavioural ALU.
module tb_alu_issue_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid[2], cmd_ready[2], res_valid[2], res_ready[2];
    logic [1:0]  cmd_op[2], alu_s[2], res_op[2];
    logic [7:0]  cmd_a[2], cmd_b[2], alu_a[2], alu_b[2], alu_y[2];
    logic [15:0] alu_z[2], res_data[2];
    logic        alu_o[2], alu_carry[2], res_carry[2], res_ovf[2], busy[2];
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    logic        res_zero[2];
`endif
    int total = 0;
    int bad = 0;
    int settle[2] = '{1, 4};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [8:0]  sum;
        assign sum          = {1'b0, alu_a[g]} + {1'b0, alu_b[g]};
        assign alu_z[g]     = {8'h00, alu_a[g]} * {8'h00, alu_b[g]};
        assign alu_carry[g] = sum[8];
        assign alu_o[g]     = (alu_a[g][7] == alu_b[g][7]) && (sum[7] != alu_a[g][7]);
        assign alu_y[g]     = alu_s[g] == 2'b00 ? sum[7:0] :
                              alu_s[g] == 2'b01 ? alu_a[g] & alu_b[g] :
                              alu_s[g] == 2'b10 ? alu_a[g] ^ alu_b[g] : alu_z[g][7:0];
        alu_issue_ctrl #(.SETTLE_CYCLES(g == 0 ? 1 : 4)) u_dut (
            .clk(clk), .rst(rst),
            .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]),
            .cmd_op(cmd_op[g]), .cmd_a(cmd_a[g]), .cmd_b(cmd_b[g]),
            .alu_s(alu_s[g]), .alu_a(alu_a[g]), .alu_b(alu_b[g]),
            .alu_y(alu_y[g]), .alu_z(alu_z[g]), .alu_o(alu_o[g]), .alu_carry(alu_carry[g]),
            .res_valid(res_valid[g]), .res_ready(res_ready[g]),
            .res_data(res_data[g]), .res_op(res_op[g]),
            .res_carry(res_carry[g]), .res_ovf(res_ovf[g]),
`ifdef ALU_ISSUE_ZERO_FLAG_EN
            .res_zero(res_zero[g]),
`endif
            .busy(busy[g])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: integer arithmetic straight from the op table
    task automatic ref_calc(input int op, input int a, input int b, output int d, output int c, output int o);
        int sa, sb;
        sa = a > 127 ? a - 256 : a;
        sb = b > 127 ? b - 256 : b;
        c = 0;
        o = 0;
        case (op)
            0: begin d = (a + b) % 256; c = (a + b) > 255; o = (sa + sb > 127) || (sa + sb < -128); end
            1: d = a & b;
            2: d = a ^ b;
            default: d = a * b;
        endcase
    endtask

    task automatic rst_chk(input int k);
        chk("rst_cmd_ready", cmd_ready[k], 1);
        chk("rst_res_valid", res_valid[k], 0);
        chk("rst_busy", busy[k], 0);
        chk("rst_alu_s", alu_s[k], 0);
        chk("rst_alu_a", alu_a[k], 0);
        chk("rst_alu_b", alu_b[k], 0);
        chk("rst_res_data", res_data[k], 0);
        chk("rst_res_op", res_op[k], 0);
        chk("rst_res_carry", res_carry[k], 0);
        chk("rst_res_ovf", res_ovf[k], 0);
`ifdef ALU_ISSUE_ZERO_FLAG_EN
        chk("rst_res_zero", res_zero[k], 0);
`endif
    endtask

    task automatic issue(input int k, input int op, input int a, input int b, input int hold, output int waited);
        int d, c, o, lat;
        ref_calc(op, a, b, d, c, o);
        cmd_valid[k] = 1'b1;
        cmd_op[k] = 2'(op);
        cmd_a[k] = 8'(a);
        cmd_b[k] = 8'(b);
        res_ready[k] = 1'b0;
        waited = 0;
        while (!cmd_ready[k] && waited < 50) begin tick(); waited++; end
        chk("accept_timeout", waited < 50, 1);
        tick();
        // scramble the command bus; it must be ignored from here on
        cmd_op[k] = ~2'(op);
        cmd_a[k] = ~8'(a);
        cmd_b[k] = 8'(a ^ b ^ 8'h5c);
        chk("acc_alu_s", alu_s[k], op);
        chk("acc_alu_a", alu_a[k], a);
        chk("acc_alu_b", alu_b[k], b);
        chk("acc_cmd_ready", cmd_ready[k], 0);
        chk("acc_busy", busy[k], 1);
        lat = 1;
        tick();
        while (!res_valid[k] && lat < 40) begin
            chk("drv_alu_a", alu_a[k], a);
            chk("drv_alu_b", alu_b[k], b);
            tick();
            lat++;
        end
        chk("latency", lat, settle[k]);
        for (int i = 0; i <= hold; i++) begin
            chk("res_valid", res_valid[k], 1);
            chk("res_data", res_data[k], d);
            chk("res_op", res_op[k], op);
            chk("res_carry", res_carry[k], c);
            chk("res_ovf", res_ovf[k], o);
`ifdef ALU_ISSUE_ZERO_FLAG_EN
            chk("res_zero", res_zero[k], d == 0);
`endif
            chk("res_cmd_ready", cmd_ready[k], 0);
            chk("res_busy", busy[k], 1);
            chk("res_alu_a", alu_a[k], a);
            if (i < hold) tick();
        end
        res_ready[k] = 1'b1;
        tick();
        res_ready[k] = 1'b0;
        cmd_valid[k] = 1'b0;
        chk("hs_res_valid", res_valid[k], 0);
        chk("hs_cmd_ready", cmd_ready[k], 1);
        chk("hs_res_data_held", res_data[k], d);
        chk("hs_alu_a_held", alu_a[k], a);
    endtask

    initial begin
        int w;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            cmd_valid[k] = 1'b0; cmd_op[k] = '0; cmd_a[k] = '0; cmd_b[k] = '0; res_ready[k] = 1'b0;
        end
        #3;
        rst_chk(0);
        rst_chk(1);
        tick();
        tick();
        rst = 1'b0;
        // directed ops on the settle-1 controller
        issue(0, 0, 100, 100, 0, w);
        issue(0, 0, 200, 100, 0, w);
        issue(0, 1, 'hf0, 'h3c, 0, w);
        issue(0, 3, 'hff, 'hff, 0, w);
        issue(0, 2, 'haa, 'hff, 0, w);
        issue(0, 2, 'h5a, 'h5a, 0, w);
        // backpressure with cmd_valid held, then back-to-back accept
        issue(0, 0, 'h7f, 1, 5, w);
        issue(0, 3, 12, 13, 0, w);
        chk("b2b_wait", w, 0);
        // settle-4 controller
        issue(1, 0, 'h81, 'h81, 2, w);
        issue(1, 3, 200, 3, 0, w);
        chk("b2b_wait4", w, 0);
        // reset during DRIVE
        cmd_valid[1] = 1'b1; cmd_op[1] = 2'b00; cmd_a[1] = 5; cmd_b[1] = 6;
        tick();
        cmd_valid[1] = 1'b0;
        tick();
        chk("pre_rst_busy", busy[1], 1);
        #2 rst = 1'b1;
        #1 rst_chk(1);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("post_rst_drv_valid", res_valid[1], 0);
            tick();
        end
        // reset during RESULT
        cmd_valid[1] = 1'b1; cmd_a[1] = 9; cmd_b[1] = 9;
        tick();
        cmd_valid[1] = 1'b0;
        repeat (4) tick();
        chk("pre_rst_res_valid", res_valid[1], 1);
        #2 rst = 1'b1;
        #1 rst_chk(1);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("post_rst_res_valid", res_valid[1], 0);
            tick();
        end
        issue(1, 0, 1, 1, 0, w);
        issue(0, 0, 1, 1, 0, w);
        // randomized ops on both controllers
        for (int i = 0; i < 24; i++)
            issue(i % 2, $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3), w);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Sequential initiator for the team's combinational 8-bit ALU (select s, operands A/B, outputs Y, Z, O, carry).
- Accepts operation commands over a valid/ready handshake.
- Drives registered s/A/B into the ALU and waits a fixed settle time.
- Captures Y/Z/O/carry and presents a 16-bit result with flags over a second valid/ready handshake.
- Sits between a command source (test sequencer or host bus) and the ALU; one operation in flight at a time.

Parameters:
SETTLE_CYCLES, 1, cycles operands are held on the ALU before capture; legal range 1..15; a value outside that range is an elaboration error.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_op  in  2  00 add, 01 and, 10 xor, 11 multiply
cmd_a  in  8  operand A
cmd_b  in  8  operand B
alu_s  out  2  registered select to ALU
alu_a  out  8  registered operand A to ALU
alu_b  out  8  registered operand B to ALU
alu_y  in  8  ALU 8-bit result
alu_z  in  16  ALU 16-bit product
alu_o  in  1  ALU adder overflow
alu_carry  in  1  ALU adder carry
res_valid  out  1  result present
res_ready  in  1  consumer accepts result
res_data  out  16  result
res_op  out  2  op that produced res_data
res_carry  out  1  carry (add only)
res_ovf  out  1  signed overflow (add only)
busy  out  1  high in DRIVE or RESULT

Behaviour:
Interface (already decided): one clock, clk. Reset rst is asynchronous and active-high.

Reset values: state IDLE; every output 0 except cmd_ready, which is 1. This includes alu_s/alu_a/alu_b and all res_* outputs.

FSM states: IDLE, DRIVE, RESULT.
- IDLE: cmd_ready=1.
  - On cmd_valid&&cmd_ready: register cmd_op/cmd_a/cmd_b into alu_s/alu_a/alu_b, load settle counter with SETTLE_CYCLES-1, go to DRIVE.
- DRIVE: cmd_ready=0; counter decrements once per cycle.
  - In the cycle where counter==0, capture the ALU outputs at the clock edge and go to RESULT.
- RESULT: res_valid=1. res_data, res_op and flags are stable until the handshake completes.
  - On res_valid&&res_ready: res_valid falls at the next edge; go to IDLE.

Timing:
- Latency: command accepted at edge N gives res_valid high from edge N+SETTLE_CYCLES.
- Minimum issue interval is SETTLE_CYCLES+2 cycles. There is no accept in RESULT, even when res_ready is high.

Capture rules:
- res_data = {8'h00, alu_y} for ops 00/01/10; alu_z for op 11.
- res_carry/res_ovf = alu_carry/alu_o for op 00; forced to 0 for every other op (the ALU adder flags are always live and must be masked).

Hold behaviour:
- alu_s/alu_a/alu_b hold the last command after completion; they change only on accept.
- cmd_* inputs are ignored outside the accept cycle.
- res_* outputs hold the last result after the handshake; only res_valid drops.

Reset mid-operation: rst in DRIVE or RESULT discards the operation immediately. No result is produced and the block returns to the reset values above.

Optional Feature:
ALU_ISSUE_ZERO_FLAG_EN
- Defined: adds output res_zero (1 bit), registered at capture, equal to (res_data==0), held with the other res_* outputs, reset 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package alu_pkg holds:
  - op codes OP_ADD=2'b00, OP_AND=2'b01, OP_XOR=2'b10, OP_MUL=2'b11;
  - FSM state encoding (IDLE, DRIVE, RESULT);
  - result width constant RES_W=16.
- No sub-module. The settle counter and capture mux stay inline.
- The bench instantiates the existing ALU as the ALU model.

Test Plan:
1. Add, op=00, A=100, B=100, SETTLE_CYCLES=1 -> res_data=16'h00C8, res_carry=0, res_ovf=1, res_valid one cycle after DRIVE entry.
2. Add, op=00, A=200, B=100 -> res_data=16'h002C, res_carry=1, res_ovf=0. Then op=01, A=8'hF0, B=8'h3C -> res_data=16'h0030, carry=0, ovf=0 (flag masking).
3. Multiply, op=11, A=8'hFF, B=8'hFF -> res_data=16'hFE01. Then xor, op=10, A=8'hAA, B=8'hFF -> 16'h0055. With ALU_ISSUE_ZERO_FLAG_EN, xor 8'h5A^8'h5A -> res_zero=1.
4. Backpressure: res_ready low for 5 cycles with cmd_valid held high -> res_valid and res_data stable, cmd_ready=0, busy=1 throughout. Raise res_ready -> next command accepted exactly one IDLE cycle later.
5. SETTLE_CYCLES=4: accept at edge N -> alu_a/alu_b stable across edges N..N+4, res_valid high from edge N+4. Change cmd_a during DRIVE -> no effect on alu_a or the result.
6. Assert rst during DRIVE, then during RESULT -> outputs return to reset values asynchronously, no res_valid pulse. A subsequent add 1+1 completes normally with res_data=16'h0002.
